// File: rtl/mem_port_arbiter_if.sv
// Bundles the three requester ports, the shared response bus and the RAM port.
// Carries no logic or storage, so it adds no latency.
// Backpressure: a requester holds its request until the matching *_gnt is high.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // CPU data port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    // CPU instruction fetch port (read-only)
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    // external master port
    logic              x_req;
    logic              x_we;
    logic [ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0] x_wdata;
    logic              x_gnt;
    logic              x_rvalid;
    // shared response and stall
    logic [DATA_W-1:0] rdata;
    logic              cpu_stall;
    // RAM side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  d_req, d_we, d_addr, d_wdata,
        input  f_req, f_addr,
        input  x_req, x_we, x_addr, x_wdata,
        input  mem_rdata,
        output d_gnt, d_rvalid, f_gnt, f_rvalid, x_gnt, x_rvalid,
        output rdata, cpu_stall,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // requesters plus RAM side
    modport master (
        output d_req, d_we, d_addr, d_wdata,
        output f_req, f_addr,
        output x_req, x_we, x_addr, x_wdata,
        output mem_rdata,
        input  d_gnt, d_rvalid, f_gnt, f_rvalid, x_gnt, x_rvalid,
        input  rdata, cpu_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port among the CPU data port, the CPU fetch port and the external master.
// Latency: the grant comes in the same cycle as the request; read data returns 1 cycle after the grant.
// Backpressure: losers see no grant and hold; the CPU stalls; the external master is aged to top priority.
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_D    = 2'd1,
        RESP_F    = 2'd2,
        RESP_X    = 2'd3
    } resp_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    resp_t             resp_id_q, resp_id_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              aged;
    logic              d_gnt, f_gnt, x_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              d_rvalid, f_rvalid, x_rvalid;

    // Grant selection: d > f > x normally, x first once it has waited MAX_WAIT cycles.
    always_comb begin
        aged  = (wait_cnt_q == MAX_WAIT_C);
        d_gnt = 1'b0;
        f_gnt = 1'b0;
        x_gnt = 1'b0;
        if (reset) begin
            if (aged && bus.x_req) begin
                x_gnt = 1'b1;
            end else if (bus.d_req) begin
                d_gnt = 1'b1;
            end else if (bus.f_req) begin
                f_gnt = 1'b1;
            end else if (bus.x_req) begin
                x_gnt = 1'b1;
            end
        end
    end

    // Steer the winner onto the RAM port and note which requester owns the next read response.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        resp_id_d = RESP_NONE;
        if (d_gnt) begin
            sel_we    = bus.d_we;
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
            resp_id_d = bus.d_we ? RESP_NONE : RESP_D;
        end else if (f_gnt) begin
            sel_addr  = bus.f_addr;
            resp_id_d = RESP_F;
        end else if (x_gnt) begin
            sel_we    = bus.x_we;
            sel_addr  = bus.x_addr;
            sel_wdata = bus.x_wdata;
            resp_id_d = bus.x_we ? RESP_NONE : RESP_X;
        end
    end

    // Age the external request: clear it when x is idle or served, and saturate at MAX_WAIT.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.x_req || x_gnt) begin
            wait_cnt_d = 8'd0;
        end else if (!aged) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // State registers. Reset drops any in-flight response and the external master's aging.
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_id_q  <= RESP_NONE;
            wait_cnt_q <= 8'd0;
        end else begin
            resp_id_q  <= resp_id_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Decode the response strobes from resp_id alone, so a new grant cannot disturb a read already in flight.
    always_comb begin
        d_rvalid = reset && (resp_id_q == RESP_D);
        f_rvalid = reset && (resp_id_q == RESP_F);
        x_rvalid = reset && (resp_id_q == RESP_X);
    end

    assign bus.d_gnt     = d_gnt;
    assign bus.f_gnt     = f_gnt;
    assign bus.x_gnt     = x_gnt;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.f_rvalid  = f_rvalid;
    assign bus.x_rvalid  = x_rvalid;
    assign bus.rdata     = (d_rvalid || f_rvalid || x_rvalid) ? bus.mem_rdata : '0;
    assign bus.cpu_stall = (bus.d_req & ~d_gnt) | (bus.f_req & ~f_gnt);
    assign bus.mem_en    = d_gnt | f_gnt | x_gnt;
    assign bus.mem_we    = sel_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
endmodule
